// File: rtl/pc_seq_pkg.sv
// Shared types for the fetch PC sequencer: FSM states, redirect sources and the
// arbitrated redirect record.
package pc_seq_pkg;

   // Redirect targets are carried at this width; users slice down to their PC width.
   localparam int unsigned MAX_W = 64;

   typedef enum logic [1:0] {BOOT, RUN, PEND, HALT} state_e;

   typedef enum logic [1:0] {NONE, TRAP, MRET, BR} redir_src_e;

   typedef struct packed {
      logic             valid;
      redir_src_e       src;
      logic [MAX_W-1:0] target;
      logic             misaligned;
   } redirect_t;

   function automatic logic is_misaligned(input logic [MAX_W-1:0] target,
                                          input int unsigned      align_bits);
      logic [MAX_W-1:0] mask;
      mask = (MAX_W'(1) << align_bits) - MAX_W'(1);
      return |(target & mask);
   endfunction

endpackage

// File: rtl/pc_redirect_arb.sv
// Priority select among trap, mret and branch redirects, flagging mret/branch
// targets whose low alignment bits are nonzero.
module pc_redirect_arb
   import pc_seq_pkg::*;
#(
   parameter int unsigned      WIDTH       = 32,
   parameter logic [WIDTH-1:0] TRAP_VECTOR = 32'h0000_0100,
   parameter int unsigned      ALIGN_BITS  = 2
) (
   input  logic             trap_valid,
   input  logic             mret_valid,
   input  logic [WIDTH-1:0] mret_target,
   input  logic             br_valid,
   input  logic [WIDTH-1:0] br_target,
   output redirect_t        redir
);

   always_comb begin
      redir = '0;
      if (trap_valid) begin
         redir.valid  = 1'b1;
         redir.src    = TRAP;
         redir.target = MAX_W'(TRAP_VECTOR);
      end else if (mret_valid) begin
         redir.valid      = 1'b1;
         redir.src        = MRET;
         redir.target     = MAX_W'(mret_target);
         redir.misaligned = is_misaligned(MAX_W'(mret_target), ALIGN_BITS);
      end else if (br_valid) begin
         redir.valid      = 1'b1;
         redir.src        = BR;
         redir.target     = MAX_W'(br_target);
         redir.misaligned = is_misaligned(MAX_W'(br_target), ALIGN_BITS);
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: boot vector, sequential advance on accepted
// requests, prioritised redirects (parked while a request is stuck), halt/resume.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int unsigned      WIDTH        = 32,
   parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h0000_0064,
   parameter logic [WIDTH-1:0] TRAP_VECTOR  = 32'h0000_0100,
   parameter int unsigned      INC          = 4,
   parameter int unsigned      ALIGN_BITS   = 2,
   parameter int unsigned      CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall,
   input  logic             br_valid,
   input  logic [WIDTH-1:0] br_target,
   input  logic             mret_valid,
   input  logic [WIDTH-1:0] mret_target,
   input  logic             trap_valid,
   input  logic             halt_req,
   input  logic             resume,
   input  logic             fetch_ready,
   output logic             fetch_valid,
   output logic [WIDTH-1:0] fetch_pc,
   output logic [WIDTH-1:0] pc_next,
   output logic             fetch_squash,
   output logic             misalign_exc,
   output logic [WIDTH-1:0] bad_addr,
   output logic             halted,
   output logic [CNT_W-1:0] fetch_cnt
);

   state_e           state_q;
   logic [WIDTH-1:0] pend_target_q;
   redirect_t        redir;
   logic             accept, stuck, take;
   logic [WIDTH-1:0] redir_pc;
   logic             unused_target_hi;

   pc_redirect_arb #(
      .WIDTH       (WIDTH),
      .TRAP_VECTOR (TRAP_VECTOR),
      .ALIGN_BITS  (ALIGN_BITS)
   ) u_arb (
      .trap_valid  (trap_valid),
      .mret_valid  (mret_valid),
      .mret_target (mret_target),
      .br_valid    (br_valid),
      .br_target   (br_target),
      .redir       (redir)
   );

   assign unused_target_hi = ^redir.target[MAX_W-1:WIDTH];

   assign accept   = fetch_valid & fetch_ready;
   assign stuck    = fetch_valid & ~fetch_ready;
   assign redir_pc = redir.misaligned ? TRAP_VECTOR : redir.target[WIDTH-1:0];
   // While halted only a trap may pull the sequencer out; br/mret are dropped.
   assign take     = redir.valid & ((state_q != HALT) | (redir.src == TRAP));
   assign halted   = (state_q == HALT);

   always_comb begin
      pc_next = fetch_pc;
      case (state_q)
         RUN: begin
            if (take && !stuck) pc_next = redir_pc;
            else if (accept)    pc_next = fetch_pc + WIDTH'(INC);
         end
         PEND: begin
            if (accept) pc_next = take ? redir_pc : pend_target_q;
         end
         HALT: begin
            if (take) pc_next = redir_pc;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= BOOT;
         pend_target_q <= '0;
         fetch_pc      <= RESET_VECTOR;
         fetch_valid   <= 1'b0;
         fetch_squash  <= 1'b0;
         misalign_exc  <= 1'b0;
         bad_addr      <= '0;
         fetch_cnt     <= '0;
      end else begin
         fetch_pc     <= pc_next;
         fetch_squash <= 1'b0;
         misalign_exc <= 1'b0;
         if (accept) fetch_cnt <= fetch_cnt + CNT_W'(1);
         if (take && redir.misaligned && state_q != BOOT) begin
            misalign_exc <= 1'b1;
            bad_addr     <= redir.target[WIDTH-1:0];
         end
         case (state_q)
            BOOT: begin
               fetch_valid <= !stall;
               state_q     <= RUN;
            end
            RUN: begin
               if (take && stuck) begin
                  pend_target_q <= redir_pc;
                  state_q       <= PEND;
               end else if (take) begin
                  fetch_squash <= 1'b1;
                  fetch_valid  <= !stall;
               end else if (!stuck) begin
                  if (halt_req) begin
                     fetch_valid <= 1'b0;
                     state_q     <= HALT;
                  end else begin
                     fetch_valid <= !stall;
                  end
               end
            end
            PEND: begin
               if (accept) begin
                  fetch_squash <= 1'b1;
                  fetch_valid  <= !stall;
                  state_q      <= RUN;
               end else if (take) begin
                  pend_target_q <= redir_pc;
               end
            end
            HALT: begin
               if (take) begin
                  fetch_squash <= 1'b1;
                  fetch_valid  <= !stall;
                  state_q      <= RUN;
               end else if (resume) begin
                  fetch_valid <= !stall;
                  state_q     <= RUN;
               end
            end
            default: state_q <= BOOT;
         endcase
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus random traffic against a
// transaction-level model of the fetch PC.
module tb_pc_sequencer;

   localparam logic [31:0] RV = 32'h0000_0064;
   localparam logic [31:0] TV = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b0, br_valid = 1'b0, mret_valid = 1'b0, trap_valid = 1'b0;
   logic        halt_req = 1'b0, resume = 1'b0, fetch_ready = 1'b0;
   logic [31:0] br_target = '0, mret_target = '0;
   logic        fetch_valid, fetch_squash, misalign_exc, halted;
   logic [31:0] fetch_pc, pc_next, bad_addr, fetch_cnt;

   int checks = 0;
   int errors = 0;

   pc_sequencer dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .stall        (stall),
      .br_valid     (br_valid),
      .br_target    (br_target),
      .mret_valid   (mret_valid),
      .mret_target  (mret_target),
      .trap_valid   (trap_valid),
      .halt_req     (halt_req),
      .resume       (resume),
      .fetch_ready  (fetch_ready),
      .fetch_valid  (fetch_valid),
      .fetch_pc     (fetch_pc),
      .pc_next      (pc_next),
      .fetch_squash (fetch_squash),
      .misalign_exc (misalign_exc),
      .bad_addr     (bad_addr),
      .halted       (halted),
      .fetch_cnt    (fetch_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Model: request slot, booting/halted flags, and a queue holding a parked redirect.
   bit          m_boot, m_halt, m_valid, m_sq, m_mis;
   logic [31:0] m_pc, m_bad, m_cnt;
   logic [31:0] m_pend[$];

   task automatic model_reset();
      m_boot = 1; m_halt = 0; m_valid = 0; m_sq = 0; m_mis = 0;
      m_pc = RV; m_bad = '0; m_cnt = '0;
      m_pend.delete();
   endtask

   task automatic compare_regs(input string pfx);
      check({pfx, "_valid"}, fetch_valid, m_valid);
      check({pfx, "_pc"}, fetch_pc, m_pc);
      check({pfx, "_squash"}, fetch_squash, m_sq);
      check({pfx, "_misalign"}, misalign_exc, m_mis);
      check({pfx, "_bad_addr"}, bad_addr, m_bad);
      check({pfx, "_halted"}, halted, m_halt);
      check({pfx, "_cnt"}, fetch_cnt, m_cnt);
   endtask

   // Inputs are already applied; predict, check pc_next, clock, then compare.
   task automatic cycle();
      bit          acc, req, mis, busy;
      logic [31:0] tgt, dest;
      bit          n_boot, n_halt, n_valid;
      logic [31:0] n_pc, n_bad, n_cnt;
      acc  = m_valid && fetch_ready;
      busy = m_valid && !fetch_ready;
      req  = trap_valid || mret_valid || br_valid;
      tgt  = trap_valid ? TV : (mret_valid ? mret_target : br_target);
      mis  = !trap_valid && (tgt % 4 != 0);
      dest = mis ? TV : tgt;
      n_boot = m_boot; n_halt = m_halt; n_valid = m_valid;
      n_pc = m_pc; n_bad = m_bad; n_cnt = m_cnt + (acc ? 32'd1 : 32'd0);
      m_sq = 0; m_mis = 0;
      if (m_boot) begin
         n_boot = 0; n_valid = !stall;
      end else if (m_halt) begin
         if (trap_valid) begin
            n_halt = 0; n_pc = TV; m_sq = 1; n_valid = !stall;
         end else if (resume) begin
            n_halt = 0; n_valid = !stall;
         end
      end else begin
         if (req && mis) begin m_mis = 1; n_bad = tgt; end
         if (m_pend.size() > 0) begin
            if (acc) begin
               n_pc = req ? dest : m_pend[0];
               m_pend.delete();
               m_sq = 1; n_valid = !stall;
            end else if (req) begin
               m_pend[0] = dest;
            end
         end else if (req && busy) begin
            m_pend.push_back(dest);
         end else if (req) begin
            n_pc = dest; m_sq = 1; n_valid = !stall;
         end else begin
            if (acc) n_pc = m_pc + 32'd4;
            if (!busy) begin
               if (halt_req) begin n_halt = 1; n_valid = 0; end
               else n_valid = !stall;
            end
         end
      end
      #2;
      check("pc_next", pc_next, n_pc);
      @(posedge clk);
      #1;
      m_boot = n_boot; m_halt = n_halt; m_valid = n_valid;
      m_pc = n_pc; m_bad = n_bad; m_cnt = n_cnt;
      compare_regs("cyc");
   endtask

   task automatic step(input bit s, input bit rdy, input bit tr, input bit mr, input bit b,
                       input bit hr, input bit rs, input logic [31:0] mt,
                       input logic [31:0] bt);
      stall = s; fetch_ready = rdy; trap_valid = tr; mret_valid = mr; br_valid = b;
      halt_req = hr; resume = rs; mret_target = mt; br_target = bt;
      cycle();
   endtask

   task automatic idle(input bit rdy);
      step(0, rdy, 0, 0, 0, 0, 0, '0, '0);
   endtask

   task automatic random_steps(input int n);
      logic [31:0] mt, bt;
      for (int i = 0; i < n; i++) begin
         mt = $urandom & 32'hFFFF_FFFC;
         bt = $urandom & 32'hFFFF_FFFC;
         if ($urandom % 6 == 0) mt = mt | ($urandom & 32'h3);
         if ($urandom % 6 == 0) bt = bt | ($urandom & 32'h3);
         step(($urandom % 8) == 0, ($urandom % 4) != 0, ($urandom % 32) == 0,
              ($urandom % 16) == 0, ($urandom % 8) == 0, ($urandom % 12) == 0,
              ($urandom % 4) == 0, mt, bt);
      end
   endtask

   initial begin
      logic [31:0] held_pc;
      model_reset();
      fetch_ready = 1'b1;
      #12;
      compare_regs("reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      idle(1);
      check("boot_pc", fetch_pc, RV);
      check("boot_valid", fetch_valid, 1);
      idle(1);
      check("seq_pc", fetch_pc, 32'h68);
      check("seq_cnt", fetch_cnt, 1);

      // Branch while 0x68 is stuck: parked until the accept.
      step(0, 0, 0, 0, 1, 0, 0, '0, 32'h300);
      check("pend_hold0", fetch_pc, 32'h68);
      idle(0);
      idle(0);
      check("pend_hold2", fetch_pc, 32'h68);
      check("pend_valid", fetch_valid, 1);
      idle(1);
      check("pend_pc", fetch_pc, 32'h300);
      check("pend_squash", fetch_squash, 1);
      check("pend_cnt", fetch_cnt, 2);
      idle(1);
      check("post_pend_pc", fetch_pc, 32'h304);

      step(0, 1, 0, 0, 1, 0, 0, '0, 32'h200);
      check("br_pc", fetch_pc, 32'h200);
      check("br_squash", fetch_squash, 1);

      step(0, 1, 1, 1, 1, 0, 0, 32'h400, 32'h500);
      check("prio_pc", fetch_pc, TV);

      step(0, 1, 0, 0, 1, 0, 0, '0, 32'h202);
      check("mis_exc", misalign_exc, 1);
      check("mis_bad", bad_addr, 32'h202);
      check("mis_pc", fetch_pc, TV);
      idle(1);
      check("mis_pulse_end", misalign_exc, 0);

      step(1, 1, 0, 0, 0, 0, 0, '0, '0);
      held_pc = m_pc;
      step(0, 1, 0, 0, 0, 1, 0, '0, '0);
      check("halt_halted", halted, 1);
      check("halt_valid", fetch_valid, 0);
      idle(1);
      step(0, 1, 0, 0, 0, 0, 1, '0, '0);
      check("resume_halted", halted, 0);
      check("resume_pc", fetch_pc, held_pc);
      check("resume_valid", fetch_valid, 1);

      step(0, 1, 0, 0, 1, 0, 0, '0, 32'hFFFF_FFFC);
      check("wrap_pre", fetch_pc, 32'hFFFF_FFFC);
      idle(1);
      check("wrap_pc", fetch_pc, 32'h0);

      random_steps(2000);

      // Force a parked redirect, then assert reset mid-cycle.
      step(0, 0, 0, 0, 0, 0, 1, '0, '0);
      step(0, 0, 0, 0, 1, 0, 0, '0, 32'h40);
      check("rst_pend_valid", fetch_valid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      compare_regs("async_rst");
      check("async_rst_pc_next", pc_next, RV);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      random_steps(50);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
